// File: rtl/qosc_pkg.sv
// Shared defaults and encodings for the quadrature oscillator demod monitor.
package qosc_pkg;

    localparam int W_DEF  = 8;
    localparam int PW_DEF = 16;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    typedef enum logic {
        ACQ  = 1'b0,
        MEAS = 1'b1
    } state_e;

endpackage

// File: rtl/qosc_quadrant.sv
// Combinational quadrant classifier: sign bits of re/im select Q0..Q3.
module qosc_quadrant
    import qosc_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] re,
    input  logic [W-1:0] im,
    output logic [1:0]   quad
);

    always_comb begin
        unique case ({re[W-1], im[W-1]})
            2'b00:   quad = Q0;
            2'b10:   quad = Q1;
            2'b11:   quad = Q2;
            default: quad = Q3;
        endcase
    end

endmodule

// File: rtl/qosc_demod_monitor.sv
// Monitors an I/Q oscillator: magnitude, quadrant, rotation direction and
// revolution period with a valid/ready result handshake and sticky error flags.
module qosc_demod_monitor
    import qosc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [W-1:0]  re,
    input  logic [W-1:0]  im,
    input  logic          clr,
    output logic [2*W-1:0] mag2,
    output logic [1:0]    quad,
    output logic          dir,
    output logic [PW-1:0] period,
    output logic          period_valid,
    input  logic          period_ready,
    output logic          overrun,
    output logic          skip,
    output logic          sat
);

    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]     quad_raw;
    quad_e          quad_cur;
    logic [1:0]     step;
    logic           bnd;
    logic [2*W-1:0] re_x, im_x;
    logic [PW-1:0]  result;
    logic           overrun_set, skip_set, sat_set;

    state_e         state_q, state_d;
    quad_e          quad_q, quad_d;
    logic [2*W-1:0] mag2_q, mag2_d;
    logic           dir_q, dir_d;
    logic [PW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  period_q, period_d;
    logic           valid_q, valid_d;
    logic           first_q, first_d;
    logic           overrun_q, overrun_d;
    logic           skip_q, skip_d;
    logic           sat_q, sat_d;

    qosc_quadrant #(.W(W)) u_quadrant (
        .re   (re),
        .im   (im),
        .quad (quad_raw)
    );

    always_comb begin
        quad_cur = quad_e'(quad_raw);
        step     = quad_cur - quad_q;
        bnd      = (quad_q == Q3 && quad_cur == Q0) || (quad_q == Q0 && quad_cur == Q3);
        // sign-extend to 2W so the squares are exact, including (-2^(W-1))^2
        re_x     = {{W{re[W-1]}}, re};
        im_x     = {{W{im[W-1]}}, im};
        result   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

        state_d     = state_q;
        quad_d      = quad_q;
        mag2_d      = mag2_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        valid_d     = valid_q;
        first_d     = first_q;
        overrun_set = 1'b0;
        skip_set    = 1'b0;
        sat_set     = 1'b0;

        if (valid_q && period_ready)
            valid_d = 1'b0;

        if (en) begin
            mag2_d  = re_x * re_x + im_x * im_x;
            quad_d  = quad_cur;
            first_d = 1'b0;
            if (!first_q) begin
                case (step)
                    2'd1:    dir_d = 1'b1;
                    2'd3:    dir_d = 1'b0;
                    2'd2:    skip_set = 1'b1;
                    default: ;
                endcase
                if (state_q == ACQ) begin
                    if (bnd) begin
                        state_d = MEAS;
                        cnt_d   = '0;
                    end
                end else if (bnd) begin
                    cnt_d   = '0;
                    sat_set = (cnt_q == CNT_MAX);
                    if (valid_q && !period_ready) begin
                        overrun_set = 1'b1;
                    end else begin
                        period_d = result;
                        valid_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    sat_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end

        overrun_d = (overrun_q & ~clr) | overrun_set;
        skip_d    = (skip_q & ~clr) | skip_set;
        sat_d     = (sat_q & ~clr) | sat_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ACQ;
            quad_q    <= Q0;
            mag2_q    <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b1;
            overrun_q <= 1'b0;
            skip_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            quad_q    <= quad_d;
            mag2_q    <= mag2_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            overrun_q <= overrun_d;
            skip_q    <= skip_d;
            sat_q     <= sat_d;
        end
    end

    assign mag2         = mag2_q;
    assign quad         = quad_q;
    assign dir          = dir_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign overrun      = overrun_q;
    assign skip         = skip_q;
    assign sat          = sat_q;

endmodule
